// File: rtl/candle_pkg.sv
// rtl/candle_pkg.sv - shared states, sizes and helpers for the candle sequencer
package candle_pkg;

  localparam int NUM_CANDLES = 8;
  localparam int POS_W       = 3;
  localparam int SHAMASH_POS = 7;

  typedef enum logic [1:0] {IDLE, LIGHT, LIT, BLOW} state_t;

  // Index of the lowest lit candle; 0 when none are lit.
  function automatic logic [POS_W-1:0] lowest_lit(input logic [NUM_CANDLES-1:0] mask);
    lowest_lit = '0;
    for (int i = NUM_CANDLES - 1; i >= 0; i--) begin
      if (mask[i]) lowest_lit = POS_W'(i);
    end
  endfunction

endpackage

// File: rtl/candle_step_timer.sv
// rtl/candle_step_timer.sv - spacing down-counter between set/clear strobes
module candle_step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int CNT_W = $clog2(STEP_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(STEP_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/candle_sequencer.sv
// rtl/candle_sequencer.sv - lights/extinguishes candles one at a time for candle_controller
// Optional: CANDLE_SEQ_SHAMASH_EN reserves position 7 as the shamash, lit first and cleared last.
module candle_sequencer
  import candle_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic             sys_clk,
  input  logic             clr_async,
  input  logic [3:0]       night,
  input  logic             start,
  input  logic             blow,
  output logic [POS_W-1:0] pos_to_set,
  output logic             set_enable,
  output logic [POS_W-1:0] pos_to_clear,
  output logic             clear_enable,
  output logic             busy,
  output logic [3:0]       lit_count
);

`ifdef CANDLE_SEQ_SHAMASH_EN
  localparam logic       SHAMASH = 1'b1;
  localparam logic [3:0] MAX_TGT = 4'd7;
`else
  localparam logic       SHAMASH = 1'b0;
  localparam logic [3:0] MAX_TGT = 4'd8;
`endif

  state_t                 state;
  logic [NUM_CANDLES-1:0] lit_mask;
  logic [POS_W-1:0]       next_pos;
  logic [3:0]             tgt;
  logic [POS_W-1:0]       tgt_pos;
  logic [POS_W-1:0]       start_pos;
  logic [POS_W-1:0]       start_next;
  logic [POS_W-1:0]       low;
  logic                   start_done;
  logic                   fire_start;
  logic                   fire_set;
  logic                   fire_clear;
  logic                   expired;

  always_comb begin
    tgt        = (night > MAX_TGT) ? MAX_TGT : night;
    tgt_pos    = tgt[POS_W-1:0];
    start_pos  = SHAMASH ? POS_W'(SHAMASH_POS) : tgt_pos - 3'd1;
    start_next = SHAMASH ? tgt_pos - 3'd1 : tgt_pos - 3'd2;
    start_done = !SHAMASH && (tgt == 4'd1);
    low        = lowest_lit(lit_mask);
    fire_start = 1'b0;
    fire_set   = 1'b0;
    fire_clear = 1'b0;
    // blow wins over start everywhere it is honoured
    case (state)
      IDLE: begin
        if (blow) fire_clear = (lit_count != 4'd0);
        else if (start) fire_start = (night != 4'd0);
      end
      LIGHT: begin
        if (blow) fire_clear = 1'b1;
        else fire_set = expired;
      end
      LIT:     fire_clear = blow;
      BLOW:    fire_clear = expired;
      default: ;
    endcase
  end

  candle_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk     (sys_clk),
    .rst     (clr_async),
    .load    (fire_start | fire_set | fire_clear),
    .expired (expired)
  );

  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) begin
      state        <= IDLE;
      set_enable   <= 1'b0;
      clear_enable <= 1'b0;
      pos_to_set   <= '0;
      pos_to_clear <= '0;
      busy         <= 1'b0;
      lit_count    <= '0;
      lit_mask     <= '0;
      next_pos     <= '0;
    end else begin
      set_enable   <= fire_start | fire_set;
      clear_enable <= fire_clear;
      if (fire_start) begin
        pos_to_set          <= start_pos;
        next_pos            <= start_next;
        lit_mask[start_pos] <= 1'b1;
        lit_count           <= 4'd1;
        state               <= start_done ? LIT : LIGHT;
        busy                <= !start_done;
      end
      if (fire_set) begin
        pos_to_set         <= next_pos;
        next_pos           <= next_pos - 3'd1;
        lit_mask[next_pos] <= 1'b1;
        lit_count          <= lit_count + 4'd1;
        if (next_pos == '0) begin
          state <= LIT;
          busy  <= 1'b0;
        end
      end
      if (fire_clear) begin
        pos_to_clear  <= low;
        lit_mask[low] <= 1'b0;
        lit_count     <= lit_count - 4'd1;
        state         <= (lit_count == 4'd1) ? IDLE : BLOW;
        busy          <= (lit_count != 4'd1);
      end
    end
  end

endmodule

// File: tb/tb_candle_sequencer.sv
// tb/tb_candle_sequencer.sv - table-driven bench for candle_sequencer
module tb_candle_sequencer;

  localparam int STEP = 4;
`ifdef CANDLE_SEQ_SHAMASH_EN
  localparam bit SH   = 1'b1;
  localparam int MAXT = 7;
`else
  localparam bit SH   = 1'b0;
  localparam int MAXT = 8;
`endif

  logic       sys_clk = 1'b0;
  logic       clr_async = 1'b0;
  logic [3:0] night = 4'd0;
  logic       start = 1'b0;
  logic       blow = 1'b0;
  logic [2:0] pos_to_set;
  logic       set_enable;
  logic [2:0] pos_to_clear;
  logic       clear_enable;
  logic       busy;
  logic [3:0] lit_count;

  candle_sequencer #(.STEP_CYCLES(STEP)) dut (
    .sys_clk      (sys_clk),
    .clr_async    (clr_async),
    .night        (night),
    .start        (start),
    .blow         (blow),
    .pos_to_set   (pos_to_set),
    .set_enable   (set_enable),
    .pos_to_clear (pos_to_clear),
    .clear_enable (clear_enable),
    .busy         (busy),
    .lit_count    (lit_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       blow;
    logic [3:0] night;
    logic       se;
    logic [2:0] ps;
    logic       ce;
    logic [2:0] pc;
    logic       busy;
    logic [3:0] lit;
  } vec_t;

  vec_t       vecs[$];
  vec_t       v;
  int         m_lit;
  logic [7:0] m_mask;
  int         applied;
  int         errors;
  int         idx;

  task automatic add(input logic r, input logic s, input logic b, input logic [3:0] n,
                     input logic se, input int ps, input logic ce, input int pc,
                     input logic bz, input int lit);
    vec_t e;
    e.rst = r; e.start = s; e.blow = b; e.night = n;
    e.se = se; e.ps = 3'(ps); e.ce = ce; e.pc = 3'(pc);
    e.busy = bz; e.lit = 4'(lit);
    vecs.push_back(e);
  endtask

  task automatic quiet(input logic s, input logic b, input logic [3:0] n, input logic bz);
    add(1'b0, s, b, n, 1'b0, 0, 1'b0, 0, bz, m_lit);
  endtask

  task automatic idle_gap(input int n, input logic bz);
    for (int k = 0; k < n; k++) quiet(1'b0, 1'b0, 4'd0, bz);
  endtask

  task automatic add_rst();
    m_lit  = 0;
    m_mask = '0;
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  function automatic int lowest(input logic [7:0] m);
    for (int k = 0; k < 8; k++) if (m[k]) return k;
    return 0;
  endfunction

  // Expected set pulses for a start with night=nt, truncated to lim pulses.
  task automatic light_seq(input int nt, input int lim);
    int pos[$];
    int tgt;
    tgt = (nt > MAXT) ? MAXT : nt;
    if (SH) pos.push_back(7);
    for (int p = tgt - 1; p >= 0; p--) pos.push_back(p);
    for (int k = 0; k < pos.size() && k < lim; k++) begin
      if (k > 0) idle_gap(STEP - 1, 1'b1);
      m_lit++;
      m_mask[pos[k]] = 1'b1;
      add(1'b0, k == 0, 1'b0, 4'(nt), 1'b1, pos[k], 1'b0, 0, k != pos.size() - 1, m_lit);
    end
  endtask

  task automatic blow_seq();
    int p;
    bit first = 1'b1;
    while (m_lit > 0) begin
      if (!first) idle_gap(STEP - 1, 1'b1);
      p = lowest(m_mask);
      m_mask[p] = 1'b0;
      m_lit--;
      add(1'b0, 1'b0, first, 4'd0, 1'b0, 0, 1'b1, p, m_lit != 0, m_lit);
      first = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      errors++;
      $display("FAIL vec %0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  initial begin
    applied = 0;
    errors  = 0;
    m_lit   = 0;
    m_mask  = '0;

    add_rst();
    idle_gap(2, 1'b0);
    light_seq(3, 99);
    idle_gap(1, 1'b0);
    quiet(1'b1, 1'b0, 4'd3, 1'b0);
    idle_gap(2, 1'b0);
    blow_seq();
    quiet(1'b1, 1'b0, 4'd0, 1'b0);
    idle_gap(3, 1'b0);
    quiet(1'b1, 1'b1, 4'd3, 1'b0);
    idle_gap(3, 1'b0);
    light_seq(12, 99);
    blow_seq();
    light_seq(5, 2);
    blow_seq();
    idle_gap(2, 1'b0);
    light_seq(3, 2);
    add_rst();
    idle_gap(5, 1'b0);
    light_seq(1, 99);
    idle_gap(3, 1'b0);
    blow_seq();
    light_seq(2, 99);
    blow_seq();
    idle_gap(2, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      idx = i;
      v   = vecs[i];
      @(negedge sys_clk);
      start = v.start;
      blow  = v.blow;
      night = v.night;
      // reset vectors are checked before any clock edge to prove the clear is asynchronous
      if (v.rst) begin
        clr_async = 1'b1;
        #1;
      end else begin
        @(posedge sys_clk);
        #1;
      end
      applied++;
      chk("set_enable", int'(set_enable), int'(v.se));
      chk("clear_enable", int'(clear_enable), int'(v.ce));
      chk("busy", int'(busy), int'(v.busy));
      chk("lit_count", int'(lit_count), int'(v.lit));
      if (v.se || v.rst) chk("pos_to_set", int'(pos_to_set), int'(v.ps));
      if (v.ce || v.rst) chk("pos_to_clear", int'(pos_to_clear), int'(v.pc));
      if (v.rst) begin
        @(posedge sys_clk);
        #1;
        clr_async = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule

// File: doc/candle_sequencer.md
Name: candle_sequencer

Overview:
- Upstream command generator for candle_controller.
- On a start request it lights a night's candle count one at a time, with a fixed spacing between candles.
- On a blow request it extinguishes the lit candles one at a time.
- Drives candle_controller's pos_to_set/set_enable and pos_to_clear/clear_enable directly; shares sys_clk and clr_async with it.

Parameters:
- STEP_CYCLES, 4, cycles between consecutive set/clear pulses (legal range 1..255).

Ports:
- sys_clk  input  1  system clock, rising edge.
- clr_async  input  1  reset, asynchronous and active-high.
- night  input  4  number of candles to light; 0 means none, values above 8 saturate to 8.
- start  input  1  single-cycle light request.
- blow  input  1  single-cycle extinguish request.
- pos_to_set  output  3  candle index to set; valid when set_enable=1.
- set_enable  output  1  single-cycle set strobe to candle_controller.
- pos_to_clear  output  3  candle index to clear; valid when clear_enable=1.
- clear_enable  output  1  single-cycle clear strobe to candle_controller.
- busy  output  1  high in LIGHT or BLOW.
- lit_count  output  4  number of candles this block has set and not yet cleared (0..8).

Behaviour:
- All outputs are registered.
- Reset (clr_async=1, asynchronous) drives: state IDLE, set_enable=0, clear_enable=0, pos_to_set=0, pos_to_clear=0, busy=0, lit_count=0, step counter=0.
- States and transitions:
  - IDLE:
    - start=1 with night>=1 latches target=min(night,8) and goes to LIGHT.
    - start=1 with night=0 is ignored.
    - blow=1 with lit_count>0 goes to BLOW; with lit_count=0 it is ignored.
    - start and blow in the same cycle: blow takes priority.
  - LIGHT:
    - First set_enable pulse in the cycle after start is sampled; subsequent pulses exactly STEP_CYCLES cycles apart.
    - Lighting order is newest-first: positions target-1 down to 0.
    - lit_count increments in the same cycle as each set_enable.
    - After the pulse for position 0, goes to LIT.
    - start is ignored.
    - blow aborts lighting immediately (no further set pulses) and goes to BLOW.
  - LIT:
    - start is ignored; candles must be blown out first.
    - blow goes to BLOW.
  - BLOW:
    - First clear_enable pulse in the cycle after entry; subsequent pulses STEP_CYCLES apart.
    - Clears lit positions in ascending order, starting at the lowest lit index.
    - lit_count decrements with each clear_enable.
    - When lit_count reaches 0, goes to IDLE.
    - start and blow are ignored.
- set_enable and clear_enable are never high in the same cycle.
- Each strobe is high for exactly one cycle.
- With STEP_CYCLES=1, pulses occur on consecutive cycles.
- Step counter width is $clog2(STEP_CYCLES+1).
- Counter reloads to STEP_CYCLES-1 after each pulse and counts down to 0.
- busy=1 in LIGHT and BLOW; busy=0 in IDLE and LIT.
- Reset mid-operation aborts immediately with no further strobes; candle_controller is cleared by the same clr_async.

Optional Feature:
- Macro: CANDLE_SEQ_SHAMASH_EN.
- Defined:
  - Position 7 is the shamash.
  - Every LIGHT sequence first sets position 7, then target candles starting at target-1.
  - night saturates to 7.
  - lit_count includes the shamash.
  - BLOW clears ascending, so the shamash (index 7) is cleared last.
  - Max total LIGHT duration is 8 pulses.
- Undefined: positions 0..7 are all ordinary candles, as described above.

Decomposition:
- Shared package candle_pkg holds:
  - state enumeration (IDLE, LIGHT, LIT, BLOW);
  - NUM_CANDLES=8 and POS_W=3;
  - SHAMASH_POS=7.
- One natural sub-module: candle_step_timer (the STEP_CYCLES down-counter with load/expire).
- FSM and position/lit_count logic stay in candle_sequencer.

Test Plan:
- Reset, then night=3, start pulse, STEP_CYCLES=4:
  - set_enable pulses at cycles 1, 5, 9 after start with pos 2, 1, 0;
  - ends in LIT with lit_count=3, busy=0.
- From lit_count=3, blow:
  - clear_enable pulses at pos 0, 1, 2 spaced 4 cycles apart;
  - returns to IDLE, lit_count=0.
- night=0 start → no strobes, state stays IDLE. night=12 start → 8 set pulses, pos 7 down to 0.
- night=5, start, then blow after the 2nd set pulse:
  - no 3rd set pulse;
  - clears pos 3 then 4;
  - lit_count ends at 0.
- start and blow together in IDLE with lit_count=0 → nothing happens. start during LIT → ignored.
- Assert clr_async mid-LIGHT:
  - all outputs 0 immediately (asynchronously);
  - after release, a new start with night=1 produces a single set of pos 0.
  - With CANDLE_SEQ_SHAMASH_EN, night=2 gives sets at pos 7, 1, 0.
